fetch_unit: RTL and testbench

Instruction fetch stage of the 16-bit custom processor. Owns the 8-bit program counter and issues pipelined, in-order reads to instruction memory. It buffers returned instruction words in a small prefetch FIFO and hands them, tagged with their PC, to the main control logic over a valid/ready handshake. A branch/jump redirect from the control logic flushes the buffer, retargets the PC and discards any stale in-flight responses.

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem reads, buffers words with their PC for control.
// Response-to-instr_valid is one cycle; issue is credit-limited so buffered + in-flight never exceed DEPTH.
module fetch_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 2;

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      outstanding_q, outstanding_d;
  logic [CW-1:0]      discard_q, discard_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      sq_rd_q, sq_rd_d, sq_wr_q, sq_wr_d;
  logic [PC_W-1:0]    fifo_pc_q  [DEPTH];
  logic [INSTR_W-1:0] fifo_ins_q [DEPTH];
  logic [PC_W-1:0]    side_pc_q  [DEPTH];

  logic          pop;
  logic          push;
  logic [CW-1:0] in_use;

  assign instr_valid = (count_q != '0);
  assign instr       = fifo_ins_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];
  assign imem_addr   = fetch_pc_q;

  // A redirect squashes the pop, so it never frees credit in that cycle.
  assign pop      = instr_valid & instr_ready & ~redirect;
  assign push     = imem_valid & ~redirect & (discard_q == '0);
  assign in_use   = count_q + outstanding_q - CW'(pop);
  assign imem_req = ~rst & ~redirect & (in_use < CW'(DEPTH));

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q + CW'(imem_req) - CW'(imem_valid);
    discard_d     = discard_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    sq_wr_d       = imem_req   ? sq_wr_q + AW'(1) : sq_wr_q;
    sq_rd_d       = imem_valid ? sq_rd_q + AW'(1) : sq_rd_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      discard_d  = outstanding_q - CW'(imem_valid);
      wr_ptr_d   = rd_ptr_q;
    end else begin
      if (imem_req) fetch_pc_d = fetch_pc_q + PC_W'(1);
      if (imem_valid && discard_q != '0) discard_d = discard_q - CW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      // Draining to empty parks both pointers on the head so instr/instr_pc keep their last value.
      if (pop && !(count_q == CW'(1) && !push)) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      else if (pop && count_q == CW'(1)) wr_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      sq_rd_q       <= '0;
      sq_wr_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]  <= '0;
        fifo_ins_q[i] <= '0;
        side_pc_q[i]  <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      sq_rd_q       <= sq_rd_d;
      sq_wr_q       <= sq_wr_d;
      if (push) begin
        fifo_pc_q[wr_ptr_q]  <= side_pc_q[sq_rd_q];
        fifo_ins_q[wr_ptr_q] <= imem_rdata;
      end
      if (imem_req) side_pc_q[sq_wr_q] <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with configurable latency, scoreboard of expected
// {pc, instr} pushed on memory response and popped on delivery, plus a vector table and corner sequences.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;

  fetch_unit #(.PC_W(8), .INSTR_W(16), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] pc;
    int         due;
    int         ep;
  } req_t;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ins;
  } exp_t;

  typedef struct {
    logic       ready;
    logic       exp_req;
    logic [7:0] exp_addr;
    logic       exp_valid;
    logic [7:0] exp_pc;
  } vec_t;

  req_t       pend[$];
  exp_t       sb[$];
  logic [7:0] dlog[$];
  int         dcyc[$];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rel0 = 0;
  int         epoch = 0;
  int         last_due = -1;
  int         lat_fix = 1;
  logic [7:0] fetch_m = '0;
  bit         just_reset = 0;

  logic        obs_req, obs_valid;
  logic [7:0]  obs_addr, obs_pc;
  logic [15:0] obs_ins;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model the spec at the negedge of each cycle, then apply this cycle's events to the model.
  task automatic observe();
    bit   ev, pop, er;
    int   lat;
    req_t hd, n;
    exp_t e;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = instr_valid;
    obs_pc    = instr_pc;
    obs_ins   = instr;
    if (rst) begin
      chk("req_in_reset", imem_req, 0);
      pend.delete();
      sb.delete();
      fetch_m    = '0;
      last_due   = cyc;
      just_reset = 1;
      return;
    end
    if (just_reset) begin
      chk("rst_addr", imem_addr, 0);
      chk("rst_instr", instr, 0);
      chk("rst_instr_pc", instr_pc, 0);
      just_reset = 0;
      rel0 = cyc;
    end
    ev = (sb.size() > 0);
    chk("instr_valid", instr_valid, ev);
    if (ev && instr_valid) begin
      chk("instr_pc", instr_pc, sb[0].pc);
      chk("instr", instr, sb[0].ins);
    end
    pop = ev && instr_ready && !redirect;
    er  = !redirect && (sb.size() + pend.size() - int'(pop) < DEPTH);
    chk("imem_req", imem_req, er);
    if (imem_req && er) chk("imem_addr", imem_addr, fetch_m);
    if (pop) begin
      dlog.push_back(sb[0].pc);
      dcyc.push_back(cyc);
      sb.delete(0);
    end
    if (imem_valid) begin
      hd = pend.pop_front();
      if (!redirect && hd.ep == epoch) begin
        e.pc  = hd.pc;
        e.ins = {8'hA5, hd.pc};
        sb.push_back(e);
      end
    end
    if (redirect) begin
      sb.delete();
      epoch++;
      fetch_m = redirect_pc;
    end
    if (imem_req) begin
      lat    = (lat_fix == 0) ? int'($urandom_range(1, 4)) : lat_fix;
      n.addr = imem_addr;
      n.pc   = fetch_m;
      n.ep   = epoch;
      n.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = n.due;
      pend.push_back(n);
      fetch_m = fetch_m + 8'd1;
    end
    if (sb.size() + pend.size() > DEPTH)
      chk("credit_bound", sb.size() + pend.size(), DEPTH);
  endtask

  task automatic tick(input logic r, input logic rd, input logic [7:0] rp);
    instr_ready = r;
    redirect    = rd;
    redirect_pc = rp;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_valid = 1'b1;
      imem_rdata = {8'hA5, pend[0].addr};
    end else begin
      imem_valid = 1'b0;
      imem_rdata = '0;
    end
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
  endtask

  vec_t       tbl[11];
  logic [7:0] wrap_exp[4];
  logic [15:0] word;
  int          rc;

  initial begin
    rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_valid = 1'b0; imem_rdata = '0;

    // Backpressure from reset, L=1: ready low six cycles, then released.
    tbl[0]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 8'h01, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[6]  = '{1'b1, 1'b1, 8'h02, 1'b1, 8'h00};
    tbl[7]  = '{1'b1, 1'b1, 8'h03, 1'b1, 8'h01};
    tbl[8]  = '{1'b1, 1'b1, 8'h04, 1'b1, 8'h02};
    tbl[9]  = '{1'b1, 1'b1, 8'h05, 1'b1, 8'h03};
    tbl[10] = '{1'b1, 1'b1, 8'h06, 1'b1, 8'h04};
    wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    @(posedge clk);
    #1;

    lat_fix = 1;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].ready, 1'b0, 8'h00);
      chk("tbl_req", obs_req, tbl[i].exp_req);
      if (tbl[i].exp_req) chk("tbl_addr", obs_addr, tbl[i].exp_addr);
      chk("tbl_valid", obs_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        word = {8'hA5, tbl[i].exp_pc};
        chk("tbl_pc", obs_pc, tbl[i].exp_pc);
        chk("tbl_instr", obs_ins, word);
      end
    end

    // Free run from reset, L=1.
    do_reset();
    dlog.delete(); dcyc.delete();
    repeat (10) tick(1'b1, 1'b0, 8'h00);
    chk("free_count", dlog.size() >= 8, 1);
    if (dlog.size() >= 8) begin
      for (int i = 0; i < 8; i++) chk("free_pc", dlog[i], i);
      chk("first_valid_lat", dcyc[0] - rel0, 2);
    end

    // Redirect to FE while a response arrives and the head is being popped.
    rc = cyc;
    tick(1'b1, 1'b1, 8'hFE);
    dlog.delete(); dcyc.delete();
    repeat (8) tick(1'b1, 1'b0, 8'h00);
    chk("wrap_count", dlog.size() >= 4, 1);
    if (dlog.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("wrap_pc", dlog[i], wrap_exp[i]);
      chk("redirect_lat", dcyc[0] - rc, 3);
    end

    // Redirect with two requests in flight at L=3.
    lat_fix = 3;
    do_reset();
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h40);
    dlog.delete(); dcyc.delete();
    repeat (12) tick(1'b1, 1'b0, 8'h00);
    chk("l3_count", dlog.size() >= 2, 1);
    if (dlog.size() >= 2) begin
      chk("l3_first_pc", dlog[0], 8'h40);
      chk("l3_second_pc", dlog[1], 8'h41);
    end

    // Random latency, ready and redirects.
    lat_fix = 0;
    do_reset();
    repeat (1000)
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 8'($urandom_range(0, 255)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
